rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: A (ALU result) and B (load/memory result).
- Each cycle it grants at most one request, round-robin by default.
- It registers the winning address and data, then drives a one-hot write-enable vector (one bit per 16-bit register's we input) and a common write-data bus.
- Sits between the writeback stage and the register file.

---
 rtl/rf_write_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Arbitrates two writeback requesters (A = ALU, B = load) onto the
//            single register-file write port. Grants are combinational; the
//            winning address/data are registered and presented as a one-hot
//            write-enable vector plus a shared write-data bus.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int DW      = 16,
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int RR_EN   = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            rst,       // asynchronous, active-low
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            b_ready,
  output logic [NREG-1:0] we,
  output logic [DW-1:0]   wdata,
  output logic            busy,
  output logic [7:0]      conflict_cnt
);

  localparam logic [7:0] c_CNT_MAX = 8'hFF;

  // Priority pointer: which requester wins when both are valid.
  typedef enum logic [0:0] {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e           prio_q, prio_d;
  logic [NREG-1:0] we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic [NREG-1:0] w_dec;
  logic            w_fire;
  logic            w_r0_hit;

  // Grant decision and the winning request's address/data.
  always_comb begin
    a_ready    = a_valid & (~b_valid | (prio_q == PRIO_A));
    b_ready    = b_valid & (~a_valid | (prio_q == PRIO_B));
    busy       = (a_valid & ~a_ready) | (b_valid & ~b_ready);
    w_fire     = a_ready | b_ready;
    w_sel_addr = b_ready ? b_addr : a_addr;
    w_sel_data = b_ready ? b_data : a_data;
    w_r0_hit   = (ZERO_R0 != 0) && (w_sel_addr == '0);
  end

  // Address decode: only indices below NREG exist, so an out-of-range
  // address naturally decodes to an all-zero vector.
  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_dec
      assign w_dec[i] = (w_sel_addr == AW'(i));
    end
  endgenerate

  // Next-state computation for write stage, priority pointer and counter.
  always_comb begin
    we_d    = '0;
    wdata_d = wdata_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;

    if (w_fire) begin
      wdata_d = w_sel_data;
      if (!w_r0_hit) begin
        we_d = w_dec;
      end
    end

    // After a grant the other requester gets priority next time.
    if (RR_EN == 0) begin
      prio_d = PRIO_A;
    end else if (a_ready) begin
      prio_d = PRIO_B;
    end else if (b_ready) begin
      prio_d = PRIO_A;
    end

    if (a_valid && b_valid && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers; reset drops any pending write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q  <= PRIO_A;
      we_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      prio_q  <= prio_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign we           = we_q;
  assign wdata        = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Purpose  : Self-checking bench for rf_write_arbiter. One instance runs with
//            round-robin priority, one with fixed priority; sel_fp chooses
//            which instance is being checked. Expected write-stage results
//            are queued by the stimulus and popped by a monitor after each
//            rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;

  logic        rr_a_ready, rr_b_ready, rr_busy;
  logic [7:0]  rr_we, rr_cnt;
  logic [15:0] rr_wdata;
  logic        fp_a_ready, fp_b_ready, fp_busy;
  logic [7:0]  fp_we, fp_cnt;
  logic [15:0] fp_wdata;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DW(16), .NREG(8), .AW(3), .RR_EN(1), .ZERO_R0(1)) u_rr (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(rr_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(rr_b_ready),
    .we(rr_we), .wdata(rr_wdata), .busy(rr_busy), .conflict_cnt(rr_cnt)
  );

  rf_write_arbiter #(.DW(16), .NREG(8), .AW(3), .RR_EN(0), .ZERO_R0(1)) u_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(fp_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(fp_b_ready),
    .we(fp_we), .wdata(fp_wdata), .busy(fp_busy), .conflict_cnt(fp_cnt)
  );

  // Instance under check
  logic sel_fp;
  wire        d_a_ready = sel_fp ? fp_a_ready : rr_a_ready;
  wire        d_b_ready = sel_fp ? fp_b_ready : rr_b_ready;
  wire        d_busy    = sel_fp ? fp_busy    : rr_busy;
  wire [7:0]  d_we      = sel_fp ? fp_we      : rr_we;
  wire [15:0] d_wdata   = sel_fp ? fp_wdata   : rr_wdata;
  wire [7:0]  d_cnt     = sel_fp ? fp_cnt     : rr_cnt;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model state
  typedef struct packed {
    logic [7:0]  we;
    logic [15:0] wd;
    logic [7:0]  cnt;
  } rec_t;

  rec_t        exp_q[$];
  bit          mon_en;
  bit          m_prio_b;
  int          m_cnt;
  logic [15:0] m_wdata;

  function automatic logic [7:0] exp_we(input logic [2:0] addr);
    logic [7:0] one;
    one = 8'd1;
    if (addr == 3'd0) return 8'd0;   // R0 writes are discarded
    return one << addr;
  endfunction

  // Monitor: after every edge compare registered outputs with the queue head.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("we", d_we, r.we);
        chk("wdata", d_wdata, r.wd);
        chk("conflict_cnt", d_cnt, r.cnt);
      end
    end
  end

  // One cycle of stimulus: drive, check grants, queue expected write result.
  task automatic step(input bit av, input logic [2:0] aa, input logic [15:0] ad,
                      input bit bv, input logic [2:0] ba, input logic [15:0] bd,
                      output bit ga, output bit gb);
    rec_t r;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    ga = 1'b0; gb = 1'b0;
    if (av && bv) begin
      if (!sel_fp && m_prio_b) gb = 1'b1;
      else                     ga = 1'b1;
    end else begin
      ga = av;
      gb = bv;
    end
    chk("a_ready", d_a_ready, ga);
    chk("b_ready", d_b_ready, gb);
    chk("busy", d_busy, (av && !ga) || (bv && !gb));
    r.we = 8'd0;
    if (ga) begin r.we = exp_we(aa); m_wdata = ad; end
    if (gb) begin r.we = exp_we(ba); m_wdata = bd; end
    if (av && bv && m_cnt < 255) m_cnt++;
    if (!sel_fp && (ga || gb)) m_prio_b = ga;
    r.wd  = m_wdata;
    r.cnt = 8'(m_cnt);
    exp_q.push_back(r);
    mon_en = 1'b1;
  endtask

  task automatic idle();
    bit ga, gb;
    step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, ga, gb);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", d_we, 8'd0);
    chk("rst_wdata", d_wdata, 16'd0);
    chk("rst_cnt", d_cnt, 8'd0);
    chk("rst_a_ready", d_a_ready, 1'b0);
    chk("rst_b_ready", d_b_ready, 1'b0);
    chk("rst_busy", d_busy, 1'b0);
    m_prio_b = 1'b0;
    m_cnt    = 0;
    m_wdata  = 16'd0;
    rst = 1'b1;
  endtask

  // Protocol-compliant random requesters: hold a request until granted.
  task automatic run_random(input int n, input bit force_both);
    bit ap = 0, bp = 0, ga, gb;
    logic [2:0]  aa = '0, ba = '0;
    logic [15:0] ad = '0, bd = '0;
    for (int k = 0; k < n; k++) begin
      if (!ap && (force_both || $urandom_range(0, 2) != 0)) begin
        ap = 1; aa = 3'($urandom_range(0, 7)); ad = 16'($urandom);
      end
      if (!bp && (force_both || $urandom_range(0, 2) != 0)) begin
        bp = 1; ba = 3'($urandom_range(0, 7)); bd = 16'($urandom);
      end
      step(ap, aa, ad, bp, ba, bd, ga, gb);
      if (ga) ap = 0;
      if (gb) bp = 0;
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ga, gb;
    rst = 1'b0; sel_fp = 1'b0; mon_en = 1'b0;
    a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    m_prio_b = 0; m_cnt = 0; m_wdata = 0;

    // Reset then idle
    do_reset();
    idle(); idle();

    // Single A write, then data holds with we cleared
    do_reset();
    step(1, 3'd3, 16'hBEEF, 0, 3'd0, 16'd0, ga, gb);
    idle(); idle();

    // Contention under round-robin: A first, then B
    do_reset();
    step(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, ga, gb);
    step(0, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, ga, gb);
    idle();

    // Same-address collision: prio requester first, other lands last
    step(1, 3'd4, 16'hAAAA, 1, 3'd4, 16'hBBBB, ga, gb);
    if (ga) step(0, 3'd4, 16'hAAAA, 1, 3'd4, 16'hBBBB, ga, gb);
    else    step(1, 3'd4, 16'hAAAA, 0, 3'd4, 16'hBBBB, ga, gb);
    idle();

    // R0 suppression
    step(1, 3'd0, 16'hFFFF, 0, 3'd0, 16'd0, ga, gb);
    idle();

    // Fixed priority: both continuously valid for 4 cycles
    sel_fp = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++)
      step(1, 3'(k + 1), 16'(16'h0100 + k), 1, 3'd7, 16'h7777, ga, gb);
    idle();
    run_random(200, 1'b0);

    // Round-robin random traffic, then saturation of the conflict counter
    sel_fp = 1'b0;
    do_reset();
    run_random(400, 1'b0);
    run_random(300, 1'b1);
    chk("cnt_saturated", d_cnt, 8'hFF);

    // Reset mid-operation: granted write to R5 must never pulse
    step(1, 3'd6, 16'h1234, 0, 3'd0, 16'd0, ga, gb);
    @(negedge clk);
    a_valid = 1; a_addr = 3'd5; a_data = 16'h5555; b_valid = 0;
    #1;
    chk("mid_a_ready", d_a_ready, 1'b1);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", d_we, 8'd0);
    chk("mid_rst_wdata", d_wdata, 16'd0);
    chk("mid_rst_cnt", d_cnt, 8'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_we_after_edge", d_we, 8'd0);
    @(negedge clk);
    a_valid = 0;
    rst = 1'b1;
    m_prio_b = 0; m_cnt = 0; m_wdata = 0;
    idle();
    step(0, 3'd0, 16'd0, 1, 3'd2, 16'h4321, ga, gb);
    idle();
    @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
